// File: rtl/irq_ctrl.sv
// Interrupt controller for the single-cycle MIPS core: edge-captured pending bits,
// software mask, and an IDLE/REQ/SERVICE sequencer for the core's irq request.
module irq_ctrl #(
    parameter int NSRC = 4,
    parameter int CW   = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic            kernel,
    input  logic            take,
    input  logic            eret,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_wdata,
    output logic            irq,
    output logic [CW-1:0]   cause,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic [15:0]     irq_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] src_q, src_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic            in_service_q, in_service_d;
    logic            irq_q, irq_d;
    logic [15:0]     irq_cnt_q, irq_cnt_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] auto_clr;
    logic [CW-1:0]   sel;
    logic            any_active;
    logic            accept;

    assign rise       = irq_src & ~src_q;
    assign active     = pend_q & mask_q;
    assign any_active = |active;
    assign clr_bits   = clr_we ? clr_wdata : '0;
    assign accept     = (state_q == REQ) && take;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = CW'(i);
            end
        end
    end

    // A take that races a withdrawal may see no active source; nothing to clear then.
    always_comb begin
        auto_clr = '0;
        if (accept && any_active) begin
            auto_clr = NSRC'(1) << sel;
        end
    end

    always_comb begin
        src_d  = irq_src;
        pend_d = (pend_q & ~clr_bits & ~auto_clr) | rise;
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        in_service_d = in_service_q;
        irq_cnt_d    = irq_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_active && !kernel) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (take) begin
                    state_d      = SERVICE;
                    cause_d      = sel;
                    in_service_d = 1'b1;
                    if (irq_cnt_q != 16'hFFFF) begin
                        irq_cnt_d = irq_cnt_q + 16'd1;
                    end
                end else if (!any_active || kernel) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            cause_q      <= '0;
            in_service_q <= 1'b0;
            irq_q        <= 1'b0;
            irq_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            cause_q      <= cause_d;
            in_service_q <= in_service_d;
            irq_q        <= irq_d;
            irq_cnt_q    <= irq_cnt_d;
        end
    end

    assign irq        = irq_q;
    assign cause      = cause_q;
    assign in_service = in_service_q;
    assign pending    = pend_q;
    assign mask       = mask_q;
    assign irq_cnt    = irq_cnt_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a flag-based behavioural model of the controller.
module tb_irq_ctrl;
    localparam int NSRC = 4;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic            kernel = 1'b0;
    logic            take = 1'b0;
    logic            eret = 1'b0;
    logic            mask_we = 1'b0;
    logic [NSRC-1:0] mask_wdata = '0;
    logic            clr_we = 1'b0;
    logic [NSRC-1:0] clr_wdata = '0;
    logic            irq;
    logic [CW-1:0]   cause;
    logic            in_service;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [15:0]     irq_cnt;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .kernel(kernel),
        .take(take), .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .clr_we(clr_we), .clr_wdata(clr_wdata), .irq(irq), .cause(cause),
        .in_service(in_service), .pending(pending), .mask(mask), .irq_cnt(irq_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Model: "requesting" and "servicing" flags, sets of pending/enabled sources.
    bit            m_req, m_svc;
    int            m_cause, m_cnt;
    bit [NSRC-1:0] m_pend, m_mask, m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input bit [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_req = 0; m_svc = 0; m_cause = 0; m_cnt = 0;
        m_pend = '0; m_mask = '0; m_prev = '0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".irq"}, 32'(irq), 32'(m_req));
        check({ctx, ".cause"}, 32'(cause), 32'(m_cause));
        check({ctx, ".in_service"}, 32'(in_service), 32'(m_svc));
        check({ctx, ".pending"}, 32'(pending), 32'(m_pend));
        check({ctx, ".mask"}, 32'(mask), 32'(m_mask));
        check({ctx, ".irq_cnt"}, 32'(irq_cnt), 32'(m_cnt));
    endtask

    // Called at a falling edge with inputs set; advances model and DUT one cycle.
    task automatic tick();
        bit [NSRC-1:0] rise, act, aclr, clr;
        int sel;
        rise = irq_src & ~m_prev;
        act  = m_pend & m_mask;
        sel  = lowest(act);
        clr  = clr_we ? clr_wdata : '0;
        aclr = '0;
        if (m_req && take) begin
            m_req = 0; m_svc = 1; m_cause = sel;
            if (m_cnt < 65535) m_cnt++;
            if (act != 0) aclr[sel] = 1'b1;
            $display("take: cause=%0d count=%0d", sel, m_cnt);
        end else if (m_req) begin
            if (act == 0 || kernel) m_req = 0;
        end else if (m_svc) begin
            if (eret) m_svc = 0;
        end else if (act != 0 && !kernel) begin
            m_req = 1;
        end
        m_pend = (m_pend & ~clr & ~aclr) | rise;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_src;
        @(posedge clk);
        #1;
        check_all("cyc");
        @(negedge clk);
    endtask

    task automatic set_mask(input logic [NSRC-1:0] v);
        mask_we = 1; mask_wdata = v; tick(); mask_we = 0;
    endtask

    task automatic pulse_src(input logic [NSRC-1:0] v);
        irq_src = v; tick(); irq_src = '0;
    endtask

    task automatic do_take();
        take = 1; tick(); take = 0;
    endtask

    task automatic do_eret();
        eret = 1; tick(); eret = 0;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check({tag, ".irq"}, 32'(irq), 32'd0);
        check({tag, ".cause"}, 32'(cause), 32'd0);
        check({tag, ".in_service"}, 32'(in_service), 32'd0);
        check({tag, ".pending"}, 32'(pending), 32'd0);
        check({tag, ".mask"}, 32'(mask), 32'd0);
        check({tag, ".irq_cnt"}, 32'(irq_cnt), 32'd0);
        irq_src = '0; kernel = 0; take = 0; eret = 0; mask_we = 0; clr_we = 0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset: %s", tag);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic service
        set_mask(4'b0100);
        pulse_src(4'b0100);
        check("basic.pend_after_edge", 32'(pending), 32'h4);
        check("basic.irq_not_yet", 32'(irq), 32'd0);
        tick();
        check("basic.irq_latency", 32'(irq), 32'd1);
        tick();
        check("basic.irq_held", 32'(irq), 32'd1);
        do_take();
        check("basic.irq_drop", 32'(irq), 32'd0);
        check("basic.cause", 32'(cause), 32'd2);
        check("basic.in_service", 32'(in_service), 32'd1);
        check("basic.pend_clr", 32'(pending), 32'd0);
        check("basic.cnt", 32'(irq_cnt), 32'd1);
        do_eret();
        check("basic.eret_svc", 32'(in_service), 32'd0);
        tick();
        check("basic.irq_quiet", 32'(irq), 32'd0);

        // Priority and back-to-back
        set_mask(4'b1111);
        pulse_src(4'b1010);
        tick();
        do_take();
        check("prio.cause1", 32'(cause), 32'd1);
        do_eret();
        check("prio.idle_gap", 32'(irq), 32'd0);
        tick();
        check("prio.reassert", 32'(irq), 32'd1);
        do_take();
        check("prio.cause3", 32'(cause), 32'd3);
        do_eret();
        tick();

        // Masking and withdrawal
        set_mask(4'b0000);
        pulse_src(4'b0001);
        tick();
        check("mask.irq_masked", 32'(irq), 32'd0);
        set_mask(4'b0001);
        tick();
        check("mask.irq_enabled", 32'(irq), 32'd1);
        clr_we = 1; clr_wdata = 4'b0001; tick(); clr_we = 0;
        tick();
        check("mask.withdrawn", 32'(irq), 32'd0);

        // Kernel gating
        kernel = 1;
        pulse_src(4'b0001);
        tick();
        check("kern.blocked", 32'(irq), 32'd0);
        kernel = 0; tick();
        check("kern.release", 32'(irq), 32'd1);
        kernel = 1; tick();
        check("kern.withdraw", 32'(irq), 32'd0);
        kernel = 0; tick();
        do_take();
        do_eret();
        tick();

        // Simultaneous rise and clear / rise and take
        irq_src = 4'b0001; clr_we = 1; clr_wdata = 4'b0001; tick();
        irq_src = '0; clr_we = 0;
        check("simul.rise_vs_clr", 32'(pending), 32'd1);
        tick();
        irq_src = 4'b0001; take = 1; tick();
        irq_src = '0; take = 0;
        check("simul.rise_vs_take", 32'(pending), 32'd1);
        do_eret();
        tick();
        check("simul.serviced_after", 32'(irq), 32'd1);
        do_take();
        do_eret();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit [NSRC-1:0] act;
            act        = m_pend & m_mask;
            irq_src    = NSRC'($urandom_range(0, 3) == 0 ? $urandom : 32'(irq_src));
            kernel     = ($urandom_range(0, 5) == 0);
            take       = ($urandom_range(0, 2) == 0) && !(m_req && act == 0);
            eret       = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = NSRC'($urandom);
            clr_we     = ($urandom_range(0, 11) == 0);
            clr_wdata  = NSRC'($urandom);
            tick();
        end
        irq_src = '0; kernel = 0; take = 0; eret = 0; mask_we = 0; clr_we = 0;

        // Async reset in the middle of a service
        async_reset("rst_random");
        set_mask(4'b0001);
        pulse_src(4'b0001);
        tick();
        do_take();
        check("rst.in_svc_before", 32'(in_service), 32'd1);
        async_reset("rst_service");

        // Counter saturation
        set_mask(4'b0001);
        force dut.irq_cnt_q = 16'hFFFE;
        #1;
        release dut.irq_cnt_q;
        m_cnt = 65534;
        for (int k = 0; k < 2; k++) begin
            pulse_src(4'b0001);
            tick();
            do_take();
            check("sat.cnt", 32'(irq_cnt), 32'hFFFF);
            do_eret();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sequences interrupt entry and return for the single-cycle MIPS core. It collects up to NSRC peripheral interrupt lines into a pending register, applies a software-written mask, and raises the core's `irq` request only at legal points (user mode, no interrupt in service). It holds the request until the core acknowledges, latches the cause, and re-arms on the kernel return. Registers are written through the memory-mapped peripheral bus.

## Interface
- `NSRC`, 4: number of interrupt sources, 2..8.
- `CW`, $clog2(NSRC): cause width.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_src`  in  NSRC  level interrupt lines, synchronous to `clk`; a rising edge sets pending.
- `kernel`  in  1  PC[31] of the current instruction; 1 = kernel mode.
- `take`  in  1  core is jumping to the interrupt vector this cycle.
- `eret`  in  1  core is executing the kernel-to-user return this cycle.
- `mask_we`  in  1  write the mask register.
- `mask_wdata`  in  NSRC  new mask; 1 = enabled.
- `clr_we`  in  1  write-1-to-clear the pending bits.
- `clr_wdata`  in  NSRC  pending bits to clear.
- `irq`  out  1  registered interrupt request to the control unit.
- `cause`  out  CW  index of the source being serviced.
- `in_service`  out  1  high from `take` until `eret`.
- `pending`  out  NSRC  pending register readback.
- `mask`  out  NSRC  mask register readback.
- `irq_cnt`  out  16  number of accepted interrupts; saturates at 16'hFFFF.

## Operation
- Edge detect: `src_q` <= `irq_src`, and `rise = irq_src & ~src_q`. `src_q` resets to 0, so a line that is already high after reset counts as an edge in the first cycle.
- Pending bit update, each bit independently: next = (pend & ~clr & ~auto_clr) | rise.
  - `clr` applies only when `clr_we` is high.
  - A rise and a clear in the same cycle leave the bit set.
- `active = pending & mask`. The selected source `sel` is the lowest set index of `active`.
- State machine `IDLE`, `REQ`, `SERVICE`. `irq` = (state == `REQ`), driven from a register.
  - `IDLE` -> `REQ` when `active != 0` and `kernel == 0`.
  - `REQ` -> `SERVICE` on `take`. In that same cycle:
    - `cause` <= `sel`;
    - `auto_clr` clears pending[`sel`];
    - `in_service` <= 1;
    - `irq_cnt` increments, saturating.
  - `REQ` -> `IDLE` (request withdrawn) when `take == 0` and either `active == 0` (masked or cleared) or `kernel == 1` (an exception entered first). `take` always wins over withdrawal.
  - `SERVICE` -> `IDLE` on `eret`. In that cycle `in_service` <= 0; `cause` holds its value.
- `take` outside `REQ` is ignored. `eret` outside `SERVICE` is ignored.
- Mask and pending writes are accepted in every state. A write issued by the handler during `SERVICE` does not raise `irq` until after `eret`.

## Timing
- Reset values:
  - outputs: `irq` = 0, `cause` = 0, `in_service` = 0, `pending` = 0, `mask` = 0 (all disabled), `irq_cnt` = 0;
  - internal: state = `IDLE`, `src_q` = 0.
- Latency from the `irq_src` edge to `irq`, with the source unmasked, state `IDLE` and `kernel` low:
  - the edge is seen at clock edge k and pending is visible after k;
  - `irq` goes high after edge k+1.
- `irq` stays high every cycle until `take`, or until withdrawal. It drops on the edge that samples `take`.
- After `eret` at edge e, the state is `IDLE` after e. If another source is active and `kernel` is low, `irq` reasserts after e+1. So there is a minimum of one `IDLE` cycle between services.
- Mask or clear writes take effect on the next edge. A write that removes the last active source during `REQ` drops `irq` one cycle later, unless `take` arrives on that same edge.
- Asserting `rst_n` low mid-operation clears all state immediately (asynchronously). Pending requests are lost.
- Simultaneous `rise` on the source being auto-cleared at `take`: the bit stays pending and is serviced after `eret`.

## Test plan
- Basic service: mask = 4'b0100, pulse `irq_src[2]` at cycle 0 -> `irq` = 1 at cycle 2. Then `take` at cycle 4 -> `irq` = 0, `cause` = 2, `in_service` = 1, pending = 0, `irq_cnt` = 1. Then `eret` -> `in_service` = 0 and `irq` stays 0.
- Priority and back-to-back: mask = 4'b1111, edges on src 1 and 3 in the same cycle -> `take` gives `cause` = 1. After `eret`, `irq` reasserts one cycle later and the next `take` gives `cause` = 3.
- Masking and withdrawal: pending[0] set with mask = 0 -> `irq` stays 0. Write mask = 4'b0001 -> `irq` goes high. Write `clr_wdata` = 4'b0001 during `REQ` -> `irq` drops the next cycle and state returns to `IDLE`.
- Kernel gating: `kernel` = 1 with an active source -> `irq` = 0. Drop `kernel` -> `irq` goes high after one edge. Raise `kernel` during `REQ` without `take` -> withdrawal.
- Simultaneous events: a rise on src 0 in the same cycle as a `clr_we` clear of bit 0 -> pending[0] = 1. A rise on the selected source in the same cycle as `take` -> pending stays set.
- Async reset mid-`SERVICE`, plus saturation: drop `rst_n` -> all outputs return to their reset values with no clock. Force `irq_cnt` to 16'hFFFF (or run 65535 services) and do one more `take` -> `irq_cnt` holds at 16'hFFFF.
